// File: rtl/wb_commit_unit.sv
// Write-back/commit stage: buffers execute results, decodes y1/y2 into two register-file write ports, traps user writes to PRIV_CH.
// Optional WB_BYPASS_EN adds combinational forwarding of the head entry's decoded ports.
module wb_commit_unit #(
  parameter int DATA_W   = 32,
  parameter int CH_W     = 4,
  parameter int DEPTH    = 2,
  parameter int FLAG_CH  = 9,
  parameter int SP_CH    = 13,
  parameter int PRIV_CH  = 14,
  parameter int PRIV_IRQ = 8,
  parameter logic [(2**CH_W)-1:0] INV_MASK = 16'h0400
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH_W-1:0]   in_y1_ch,
  input  logic [1:0]        in_y2_ch,
  input  logic [DATA_W-1:0] in_y1_data,
  input  logic [DATA_W-1:0] in_y2_data,
  input  logic [1:0]        sys_mode,
  input  logic              rf_ready,
  output logic              wa_en,
  output logic [CH_W-1:0]   wa_idx,
  output logic [DATA_W-1:0] wa_data,
  output logic              wb_en,
  output logic [CH_W-1:0]   wb_idx,
  output logic [DATA_W-1:0] wb_data,
  output logic              irq_req,
  output logic [7:0]        irq_num,
  input  logic              irq_ack,
  output logic              busy
`ifdef WB_BYPASS_EN
  ,
  output logic              byp_a_en,
  output logic [CH_W-1:0]   byp_a_idx,
  output logic [DATA_W-1:0] byp_a_data,
  output logic              byp_b_en,
  output logic [CH_W-1:0]   byp_b_idx,
  output logic [DATA_W-1:0] byp_b_data
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [CH_W-1:0]   y1_ch;
    logic [1:0]        y2_ch;
    logic [DATA_W-1:0] y1_data;
    logic [DATA_W-1:0] y2_data;
    logic [1:0]        mode;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              wa_en_q, wb_en_q;
  logic [CH_W-1:0]   wa_idx_q, wb_idx_q;
  logic [DATA_W-1:0] wa_data_q, wb_data_q;
  logic              irq_req_q, irq_req_d;
  logic [7:0]        irq_num_q, irq_num_d;

  entry_t            head;
  entry_t            push_entry;
  logic              head_valid, full, stall, pop, push;
  logic              dec_a_en, dec_b_en, dec_trap, dec_collide;
  logic [CH_W-1:0]   dec_b_idx;

  assign head       = mem_q[rd_ptr_q];
  assign head_valid = (count_q != '0);
  assign full       = (count_q == CNT_W'(DEPTH));

  // A pending trap freezes the queue until the interrupt controller acknowledges it.
  assign stall    = irq_req_q && !irq_ack;
  assign pop      = head_valid && rf_ready && !stall;
  assign in_ready = !full || pop;
  assign push     = in_valid && in_ready;

  assign push_entry = '{y1_ch:   in_y1_ch,
                        y2_ch:   in_y2_ch,
                        y1_data: in_y1_data,
                        y2_data: in_y2_data,
                        mode:    sys_mode};

  always_comb begin
    dec_b_en    = (head.y2_ch == 2'd1) || (head.y2_ch == 2'd2);
    dec_b_idx   = (head.y2_ch == 2'd2) ? CH_W'(SP_CH) : CH_W'(FLAG_CH);
    dec_trap    = (head.y1_ch == CH_W'(PRIV_CH)) && (head.mode == 2'b11);
    // y2 wins when both channels name the same register.
    dec_collide = dec_b_en && (head.y1_ch == dec_b_idx);
    dec_a_en    = (head.y1_ch != '0) && !INV_MASK[head.y1_ch] && !dec_trap && !dec_collide;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A new trap takes precedence over an acknowledge landing in the same cycle.
  always_comb begin
    irq_req_d = irq_req_q;
    irq_num_d = irq_num_q;
    if (pop && dec_trap) begin
      irq_req_d = 1'b1;
      irq_num_d = 8'(PRIV_IRQ);
    end else if (irq_ack) begin
      irq_req_d = 1'b0;
      irq_num_d = 8'd0;
    end
  end

  // Storage needs no reset; the pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wa_en_q   <= 1'b0;
      wa_idx_q  <= '0;
      wa_data_q <= '0;
      wb_en_q   <= 1'b0;
      wb_idx_q  <= '0;
      wb_data_q <= '0;
      irq_req_q <= 1'b0;
      irq_num_q <= 8'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      wa_en_q   <= pop && dec_a_en;
      wb_en_q   <= pop && dec_b_en;
      if (pop) begin
        wa_idx_q  <= head.y1_ch;
        wa_data_q <= head.y1_data;
        wb_idx_q  <= dec_b_idx;
        wb_data_q <= head.y2_data;
      end
      irq_req_q <= irq_req_d;
      irq_num_q <= irq_num_d;
    end
  end

  assign wa_en   = wa_en_q;
  assign wa_idx  = wa_idx_q;
  assign wa_data = wa_data_q;
  assign wb_en   = wb_en_q;
  assign wb_idx  = wb_idx_q;
  assign wb_data = wb_data_q;
  assign irq_req = irq_req_q;
  assign irq_num = irq_num_q;
  assign busy    = head_valid || irq_req_q;

`ifdef WB_BYPASS_EN
  assign byp_a_en   = head_valid && dec_a_en;
  assign byp_a_idx  = head.y1_ch;
  assign byp_a_data = head.y1_data;
  assign byp_b_en   = head_valid && dec_b_en;
  assign byp_b_idx  = dec_b_idx;
  assign byp_b_data = head.y2_data;
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_commit_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_y1_ch;
  logic [1:0]  in_y2_ch;
  logic [31:0] in_y1_data;
  logic [31:0] in_y2_data;
  logic [1:0]  sys_mode;
  logic        rf_ready;
  logic        wa_en;
  logic [3:0]  wa_idx;
  logic [31:0] wa_data;
  logic        wb_en;
  logic [3:0]  wb_idx;
  logic [31:0] wb_data;
  logic        irq_req;
  logic [7:0]  irq_num;
  logic        irq_ack;
  logic        busy;

  wb_commit_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y1_ch(in_y1_ch), .in_y2_ch(in_y2_ch),
    .in_y1_data(in_y1_data), .in_y2_data(in_y2_data),
    .sys_mode(sys_mode), .rf_ready(rf_ready),
    .wa_en(wa_en), .wa_idx(wa_idx), .wa_data(wa_data),
    .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
    .irq_req(irq_req), .irq_num(irq_num), .irq_ack(irq_ack),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  y1;
    logic [1:0]  y2;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [1:0]  mode;
  } txn_t;

  txn_t        mq[$];
  bit          m_irq;
  bit          exp_wa_en, exp_wb_en;
  logic [3:0]  exp_wa_idx, exp_wb_idx;
  logic [31:0] exp_wa_data, exp_wb_data;
  logic [15:0] inv_mask = 16'h0400;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write-port outcome of committing one result, straight from the channel rules.
  function automatic void decode(input txn_t e, output bit a_en, output bit b_en,
                                 output logic [3:0] b_idx, output bit trap);
    trap  = (e.y1 == 4'd14) && (e.mode == 2'b11);
    b_en  = (e.y2 == 2'd1) || (e.y2 == 2'd2);
    b_idx = (e.y2 == 2'd2) ? 4'd13 : 4'd9;
    a_en  = (e.y1 != 4'd0) && !inv_mask[e.y1] && !trap && !(b_en && (e.y1 == b_idx));
  endfunction

  task automatic set_in(input bit v, input logic [3:0] y1, input logic [1:0] y2,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [1:0] mode);
    in_valid   = v;
    in_y1_ch   = y1;
    in_y2_ch   = y2;
    in_y1_data = d1;
    in_y2_data = d2;
    sys_mode   = mode;
  endtask

  task automatic check_reset_values();
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_wa_en",    64'(wa_en),    64'(0));
    check("rst_wa_idx",   64'(wa_idx),   64'(0));
    check("rst_wa_data",  64'(wa_data),  64'(0));
    check("rst_wb_en",    64'(wb_en),    64'(0));
    check("rst_wb_idx",   64'(wb_idx),   64'(0));
    check("rst_wb_data",  64'(wb_data),  64'(0));
    check("rst_irq_req",  64'(irq_req),  64'(0));
    check("rst_irq_num",  64'(irq_num),  64'(0));
    check("rst_busy",     64'(busy),     64'(0));
  endtask

  // One clock cycle: predict, check in_ready, clock, check registered outputs.
  task automatic step();
    bit   stall, pop, rdy, push, a_en, b_en, trap;
    logic [3:0] b_idx;
    txn_t e, cur;
    #1;
    stall = m_irq && !irq_ack;
    pop   = (mq.size() > 0) && rf_ready && !stall;
    rdy   = (mq.size() < DEPTH) || pop;
    push  = in_valid && rdy;
    check("in_ready", 64'(in_ready), 64'(rdy));
    cur = '{y1: in_y1_ch, y2: in_y2_ch, d1: in_y1_data, d2: in_y2_data, mode: sys_mode};
    exp_wa_en = 1'b0;
    exp_wb_en = 1'b0;
    trap      = 1'b0;
    if (pop) begin
      e = mq.pop_front();
      decode(e, a_en, b_en, b_idx, trap);
      exp_wa_en   = a_en;
      exp_wb_en   = b_en;
      exp_wa_idx  = e.y1;
      exp_wa_data = e.d1;
      exp_wb_idx  = b_idx;
      exp_wb_data = e.d2;
    end
    if (push) mq.push_back(cur);
    if (pop && trap) m_irq = 1'b1;
    else if (irq_ack) m_irq = 1'b0;
    @(posedge clk);
    #1;
    check("wa_en",   64'(wa_en),   64'(exp_wa_en));
    check("wb_en",   64'(wb_en),   64'(exp_wb_en));
    check("irq_req", 64'(irq_req), 64'(m_irq));
    check("irq_num", 64'(irq_num), m_irq ? 64'(8) : 64'(0));
    check("busy",    64'(busy),    64'((mq.size() != 0) || m_irq));
    if (exp_wa_en) begin
      check("wa_idx",  64'(wa_idx),  64'(exp_wa_idx));
      check("wa_data", 64'(wa_data), 64'(exp_wa_data));
    end
    if (exp_wb_en) begin
      check("wb_idx",  64'(wb_idx),  64'(exp_wb_idx));
      check("wb_data", 64'(wb_data), 64'(exp_wb_data));
    end
  endtask

  task automatic apply_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    mq.delete();
    m_irq     = 1'b0;
    exp_wa_en = 1'b0;
    exp_wb_en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rf_ready = 1'b0;
    irq_ack  = 1'b0;
    m_irq    = 1'b0;
    set_in(1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    rst_n = 1'b1;

    // Scenario 1: single y1 write, earliest commit.
    rf_ready = 1'b1;
    set_in(1'b1, 4'd3, 2'd0, 32'hDEAD_BEEF, 32'd0, 2'b00);
    step();
    set_in(1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 2'b00);
    step();
    check("t1_wa_data", 64'(wa_data), 64'(32'hDEAD_BEEF));

    // Scenario 2: y1 and y2 both name the flag register.
    set_in(1'b1, 4'd9, 2'd1, 32'd1, 32'h55, 2'b00);
    step();
    set_in(1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 2'b00);
    step();
    check("t2_wa_en", 64'(wa_en), 64'(0));
    check("t2_wb_idx", 64'(wb_idx), 64'(9));
    check("t2_wb_data", 64'(wb_data), 64'(32'h55));

    // Scenario 3: fill the FIFO with the register file stalled, then drain.
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 4'(i + 1), 2'd0, 32'(32'h1000 + i), 32'd0, 2'b00);
      step();
    end
    check("t3_full_in_ready", 64'(in_ready), 64'(0));
    set_in(1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 2'b00);
    rf_ready = 1'b1;
    repeat (3) step();

    // Scenario 4: user-mode write to the protected channel traps; later result waits for ack.
    set_in(1'b1, 4'd14, 2'd2, 32'h77, 32'h100, 2'b11);
    step();
    set_in(1'b1, 4'd5, 2'd0, 32'hABCD, 32'd0, 2'b00);
    step();
    check("t4_wb_idx", 64'(wb_idx), 64'(13));
    check("t4_irq_num", 64'(irq_num), 64'(8));
    set_in(1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 2'b00);
    repeat (3) step();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    repeat (2) step();

    // Scenario 5: invalid y1 index and reserved y2 code write nothing but still drain.
    set_in(1'b1, 4'd10, 2'd0, 32'h1, 32'h2, 2'b00);
    step();
    set_in(1'b1, 4'd0, 2'd3, 32'h3, 32'h4, 2'b00);
    step();
    set_in(1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 2'b00);
    repeat (2) step();

    // Scenario 6: asynchronous reset with two entries queued behind a pending trap.
    set_in(1'b1, 4'd14, 2'd0, 32'h9, 32'd0, 2'b11);
    step();
    set_in(1'b1, 4'd2, 2'd0, 32'h22, 32'd0, 2'b00);
    step();
    set_in(1'b1, 4'd4, 2'd0, 32'h44, 32'd0, 2'b00);
    step();
    set_in(1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 2'b00);
    step();
    check("t6_irq_before_rst", 64'(irq_req), 64'(1));
    apply_reset();
    repeat (3) step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(99, 0) < 70), 4'($urandom_range(15, 0)), 2'($urandom_range(3, 0)),
             $urandom, $urandom, 2'($urandom_range(3, 0)));
      rf_ready = ($urandom_range(99, 0) < 70);
      irq_ack  = ($urandom_range(99, 0) < 20);
      step();
    end
    set_in(1'b0, 4'd0, 2'd0, 32'd0, 32'd0, 2'b00);
    rf_ready = 1'b1;
    irq_ack  = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
